// File: rtl/int_req_ctrl.sv
// Multi-source interrupt front end: synchronise, edge-detect, pend, mask, pick lowest index,
// pulse INT and track the INTA/eret handshake. Optional ack timeout: INT_ACK_TIMEOUT_EN.
module int_req_ctrl #(
   parameter int unsigned N_SRC       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PULSE_W     = 2,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_SRC-1:0]         irq_in,
   input  logic                     mask_we,
   input  logic [N_SRC-1:0]         mask_wdata,
   input  logic                     INTA,
   input  logic                     eret,
   output logic                     INT,
   output logic [$clog2(N_SRC)-1:0] irq_id,
   output logic [N_SRC-1:0]         pending,
   output logic [N_SRC-1:0]         mask,
   output logic                     busy
);

   localparam int unsigned IdW    = $clog2(N_SRC);
   localparam int unsigned CntMax = (ACK_TIMEOUT > PULSE_W) ? ACK_TIMEOUT : PULSE_W;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   typedef enum logic [1:0] {
      StIdle,
      StAssert,
      StWaitAck,
      StInService
   } state_e;

   state_e             state_q, state_d;
   logic [N_SRC-1:0]   sync_q [SYNC_STAGES];
   logic [N_SRC-1:0]   prev_q;
   logic [N_SRC-1:0]   pending_q, pending_d;
   logic [N_SRC-1:0]   mask_q, mask_d;
   logic [IdW-1:0]     irq_id_q, irq_id_d;
   logic               int_q, int_d;
   logic               busy_q, busy_d;
   logic [CntW-1:0]    cnt_q, cnt_d;

   logic [N_SRC-1:0]   rise;
   logic [N_SRC-1:0]   eligible;
   logic [N_SRC-1:0]   clr;
   logic [IdW-1:0]     winner;

   always_comb begin
      rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
      eligible = pending_q & ~mask_q;
      // Scan downwards so the lowest set index is the last one written.
      winner   = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = IdW'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      int_d    = int_q;
      irq_id_d = irq_id_q;
      cnt_d    = cnt_q;
      clr      = '0;

      unique case (state_q)
         StIdle: begin
            if (|eligible) begin
               state_d  = StAssert;
               irq_id_d = winner;
               int_d    = 1'b1;
               cnt_d    = '0;
            end
         end
         StAssert: begin
            if (INTA) begin
               state_d = StInService;
               int_d   = 1'b0;
               clr     = N_SRC'(1) << irq_id_q;
            end else if (cnt_q == CntW'(PULSE_W - 1)) begin
               state_d = StWaitAck;
               int_d   = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StWaitAck: begin
            if (INTA) begin
               state_d = StInService;
               clr     = N_SRC'(1) << irq_id_q;
            end
`ifdef INT_ACK_TIMEOUT_EN
            // Give up on this delivery; pending stays set so IDLE re-arbitrates.
            else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
`endif
         end
         StInService: begin
            if (eret) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            int_d   = 1'b0;
         end
      endcase

      // A rise landing on the same edge as the INTA clear keeps the bit set.
      pending_d = (pending_q & ~clr) | rise;
      mask_d    = mask_we ? mask_wdata : mask_q;
      busy_d    = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) begin
            sync_q[s] <= '0;
         end
         prev_q    <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         irq_id_q  <= '0;
         int_q     <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         state_q   <= StIdle;
      end else begin
         sync_q[0] <= irq_in;
         for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q    <= sync_q[SYNC_STAGES-1];
         pending_q <= pending_d;
         mask_q    <= mask_d;
         irq_id_q  <= irq_id_d;
         int_q     <= int_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
      end
   end

   assign INT     = int_q;
   assign irq_id  = irq_id_q;
   assign pending = pending_q;
   assign mask    = mask_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_int_req_ctrl.sv
// Table-driven bench for int_req_ctrl: per-cycle stimulus with hand-derived expectations,
// checked through a scoreboard queue one cycle after each drive.
module tb_int_req_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_in;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       INTA;
   logic       eret;
   logic       INT;
   logic [2:0] irq_id;
   logic [7:0] pending;
   logic [7:0] mask;
   logic       busy;

   always #5 clk = ~clk;

   int_req_ctrl #(
      .N_SRC      (8),
      .SYNC_STAGES(2),
      .PULSE_W    (2),
      .ACK_TIMEOUT(64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_in    (irq_in),
      .mask_we   (mask_we),
      .mask_wdata(mask_wdata),
      .INTA      (INTA),
      .eret      (eret),
      .INT       (INT),
      .irq_id    (irq_id),
      .pending   (pending),
      .mask      (mask),
      .busy      (busy)
   );

   typedef struct packed {
      logic       e_int;
      logic [2:0] e_id;
      logic [7:0] e_pend;
      logic [7:0] e_mask;
      logic       e_busy;
   } exp_t;

   typedef struct {
      logic [7:0] irq;
      logic       mwe;
      logic [7:0] mwd;
      logic       inta;
      logic       eret;
      logic       rst;
      exp_t       exp;
   } vec_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input int irq, input int mwe, input int mwd, input int inta,
                               input int er, input int r, input int ei, input int eid,
                               input int ep, input int em, input int eb);
      vec_t v;
      v.irq        = 8'(irq);
      v.mwe        = 1'(mwe);
      v.mwd        = 8'(mwd);
      v.inta       = 1'(inta);
      v.eret       = 1'(er);
      v.rst        = 1'(r);
      v.exp.e_int  = 1'(ei);
      v.exp.e_id   = 3'(eid);
      v.exp.e_pend = 8'(ep);
      v.exp.e_mask = 8'(em);
      v.exp.e_busy = 1'(eb);
      return v;
   endfunction

   function automatic void add(input int irq, input int mwe, input int mwd, input int inta,
                               input int er, input int r, input int ei, input int eid,
                               input int ep, input int em, input int eb);
      vecs.push_back(mk(irq, mwe, mwd, inta, er, r, ei, eid, ep, em, eb));
   endfunction

   task automatic check(input string tag, input int idx);
      exp_t e;
      exp_t a;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s[%0d]: scoreboard empty, nothing to compare", tag, idx);
      end else begin
         e = sb_q.pop_front();
         a = '{e_int: INT, e_id: irq_id, e_pend: pending, e_mask: mask, e_busy: busy};
         if (a !== e) begin
            n_bad++;
            $display({"FAIL %s[%0d]: got int=%b id=%0d pend=%h mask=%h busy=%b, ",
                      "want int=%b id=%0d pend=%h mask=%h busy=%b"}, tag, idx,
                     a.e_int, a.e_id, a.e_pend, a.e_mask, a.e_busy,
                     e.e_int, e.e_id, e.e_pend, e.e_mask, e.e_busy);
         end
      end
   endtask

   task automatic apply(input vec_t v, input string tag, input int idx);
      irq_in     = v.irq;
      mask_we    = v.mwe;
      mask_wdata = v.mwd;
      INTA       = v.inta;
      eret       = v.eret;
      rst        = v.rst;
      sb_q.push_back(v.exp);
      @(posedge clk);
      #1;
      check(tag, idx);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //   irq  mwe mwd  inta eret rst | int id pend mask busy
      // Reset, then a single request on line 3.
      add('h00, 0, 'h00, 0, 0, 1,  0, 0, 'h00, 'h00, 0);
      add('h08, 0, 'h00, 0, 0, 0,  0, 0, 'h00, 'h00, 0);
      add('h08, 0, 'h00, 0, 0, 0,  0, 0, 'h00, 'h00, 0);
      add('h08, 0, 'h00, 0, 0, 0,  0, 0, 'h08, 'h00, 0);
      add('h08, 0, 'h00, 0, 0, 0,  1, 3, 'h08, 'h00, 1);
      add('h08, 0, 'h00, 0, 0, 0,  1, 3, 'h08, 'h00, 1);
      add('h08, 0, 'h00, 0, 0, 0,  0, 3, 'h08, 'h00, 1);
      add('h08, 0, 'h00, 0, 0, 0,  0, 3, 'h08, 'h00, 1);
      add('h08, 0, 'h00, 1, 0, 0,  0, 3, 'h00, 'h00, 1);
      add('h08, 0, 'h00, 0, 0, 0,  0, 3, 'h00, 'h00, 1);
      add('h08, 0, 'h00, 0, 1, 0,  0, 3, 'h00, 'h00, 0);
      add('h08, 0, 'h00, 0, 0, 0,  0, 3, 'h00, 'h00, 0);
      // Lines 5 and 2 together: 2 first, 5 after eret; INTA ignored in service.
      add('h2C, 0, 'h00, 0, 0, 0,  0, 3, 'h00, 'h00, 0);
      add('h2C, 0, 'h00, 0, 0, 0,  0, 3, 'h00, 'h00, 0);
      add('h2C, 0, 'h00, 0, 0, 0,  0, 3, 'h24, 'h00, 0);
      add('h2C, 0, 'h00, 0, 0, 0,  1, 2, 'h24, 'h00, 1);
      add('h2C, 0, 'h00, 0, 0, 0,  1, 2, 'h24, 'h00, 1);
      add('h2C, 0, 'h00, 0, 0, 0,  0, 2, 'h24, 'h00, 1);
      add('h2C, 0, 'h00, 1, 0, 0,  0, 2, 'h20, 'h00, 1);
      add('h2C, 0, 'h00, 0, 1, 0,  0, 2, 'h20, 'h00, 0);
      add('h2C, 0, 'h00, 0, 0, 0,  1, 5, 'h20, 'h00, 1);
      add('h2C, 0, 'h00, 0, 0, 0,  1, 5, 'h20, 'h00, 1);
      add('h2C, 0, 'h00, 0, 0, 0,  0, 5, 'h20, 'h00, 1);
      add('h2C, 0, 'h00, 1, 0, 0,  0, 5, 'h00, 'h00, 1);
      add('h2C, 0, 'h00, 1, 0, 0,  0, 5, 'h00, 'h00, 1);
      add('h2C, 0, 'h00, 0, 1, 0,  0, 5, 'h00, 'h00, 0);
      // Masked request on line 4 waits; eret in IDLE ignored; unmask releases it.
      add('h00, 0, 'h00, 0, 0, 0,  0, 5, 'h00, 'h00, 0);
      add('h00, 1, 'h10, 0, 0, 0,  0, 5, 'h00, 'h10, 0);
      add('h10, 0, 'h00, 0, 0, 0,  0, 5, 'h00, 'h10, 0);
      add('h10, 0, 'h00, 0, 0, 0,  0, 5, 'h00, 'h10, 0);
      add('h10, 0, 'h00, 0, 0, 0,  0, 5, 'h10, 'h10, 0);
      add('h10, 0, 'h00, 0, 1, 0,  0, 5, 'h10, 'h10, 0);
      add('h10, 1, 'h00, 0, 0, 0,  0, 5, 'h10, 'h00, 0);
      add('h10, 0, 'h00, 0, 0, 0,  1, 4, 'h10, 'h00, 1);
      add('h10, 0, 'h00, 0, 0, 0,  1, 4, 'h10, 'h00, 1);
      add('h10, 0, 'h00, 0, 0, 0,  0, 4, 'h10, 'h00, 1);
      add('h10, 0, 'h00, 1, 0, 0,  0, 4, 'h00, 'h00, 1);
      add('h10, 0, 'h00, 0, 1, 0,  0, 4, 'h00, 'h00, 0);
      // Line 1 re-rises exactly on the INTA edge: set beats clear, second pulse follows.
      add('h12, 0, 'h00, 0, 0, 0,  0, 4, 'h00, 'h00, 0);
      add('h12, 0, 'h00, 0, 0, 0,  0, 4, 'h00, 'h00, 0);
      add('h12, 0, 'h00, 0, 0, 0,  0, 4, 'h02, 'h00, 0);
      add('h10, 0, 'h00, 0, 0, 0,  1, 1, 'h02, 'h00, 1);
      add('h10, 0, 'h00, 0, 0, 0,  1, 1, 'h02, 'h00, 1);
      add('h12, 0, 'h00, 0, 0, 0,  0, 1, 'h02, 'h00, 1);
      add('h12, 0, 'h00, 0, 0, 0,  0, 1, 'h02, 'h00, 1);
      add('h12, 0, 'h00, 1, 0, 0,  0, 1, 'h02, 'h00, 1);
      add('h12, 0, 'h00, 0, 1, 0,  0, 1, 'h02, 'h00, 0);
      add('h12, 0, 'h00, 0, 0, 0,  1, 1, 'h02, 'h00, 1);
      add('h12, 0, 'h00, 0, 0, 0,  1, 1, 'h02, 'h00, 1);
      add('h12, 0, 'h00, 0, 0, 0,  0, 1, 'h02, 'h00, 1);
      add('h12, 0, 'h00, 1, 0, 0,  0, 1, 'h00, 'h00, 1);
      // Reset during IN_SERVICE clears everything; later eret does nothing.
      add('h12, 1, 'h81, 0, 0, 0,  0, 1, 'h00, 'h81, 1);
      add('h00, 0, 'h00, 0, 0, 1,  0, 0, 'h00, 'h00, 0);
      add('h00, 0, 'h00, 0, 1, 0,  0, 0, 'h00, 'h00, 0);
      add('h00, 0, 'h00, 0, 0, 0,  0, 0, 'h00, 'h00, 0);
      // Lines 7 and 0 with line 0 masked: winner is the top index.
      add('h81, 1, 'h01, 0, 0, 0,  0, 0, 'h00, 'h01, 0);
      add('h81, 0, 'h00, 0, 0, 0,  0, 0, 'h00, 'h01, 0);
      add('h81, 0, 'h00, 0, 0, 0,  0, 0, 'h81, 'h01, 0);
      add('h81, 0, 'h00, 0, 0, 0,  1, 7, 'h81, 'h01, 1);
      add('h81, 0, 'h00, 0, 0, 0,  1, 7, 'h81, 'h01, 1);
      add('h81, 0, 'h00, 0, 0, 0,  0, 7, 'h81, 'h01, 1);
      add('h81, 0, 'h00, 1, 0, 0,  0, 7, 'h01, 'h01, 1);
      add('h81, 0, 'h00, 0, 1, 0,  0, 7, 'h01, 'h01, 0);
      add('h81, 0, 'h00, 0, 0, 0,  0, 7, 'h01, 'h01, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], "vec", i);
      end

      // Unmask line 0 and let it sit unacknowledged in WAIT_ACK.
      apply(mk('h81, 1, 'h00, 0, 0, 0,  0, 7, 'h01, 'h00, 0), "wait", 0);
      apply(mk('h81, 0, 'h00, 0, 0, 0,  1, 0, 'h01, 'h00, 1), "wait", 1);
      apply(mk('h81, 0, 'h00, 0, 0, 0,  1, 0, 'h01, 'h00, 1), "wait", 2);
      apply(mk('h81, 0, 'h00, 0, 0, 0,  0, 0, 'h01, 'h00, 1), "wait", 3);
`ifdef INT_ACK_TIMEOUT_EN
      for (int j = 1; j <= 67; j++) begin
         if (j < 64) begin
            apply(mk('h81, 0, 'h00, 0, 0, 0,  0, 0, 'h01, 'h00, 1), "tmo", j);
         end else if (j == 64) begin
            apply(mk('h81, 0, 'h00, 0, 0, 0,  0, 0, 'h01, 'h00, 0), "tmo", j);
         end else if (j < 67) begin
            apply(mk('h81, 0, 'h00, 0, 0, 0,  1, 0, 'h01, 'h00, 1), "tmo", j);
         end else begin
            apply(mk('h81, 0, 'h00, 0, 0, 0,  0, 0, 'h01, 'h00, 1), "tmo", j);
         end
      end
`else
      for (int j = 1; j <= 70; j++) begin
         apply(mk('h81, 0, 'h00, 0, 0, 0,  0, 0, 'h01, 'h00, 1), "hold", j);
      end
`endif
      apply(mk('h81, 0, 'h00, 1, 0, 0,  0, 0, 'h00, 'h00, 1), "ack", 0);
      apply(mk('h81, 0, 'h00, 0, 1, 0,  0, 0, 'h00, 'h00, 0), "ack", 1);
      apply(mk('h81, 0, 'h00, 0, 0, 0,  0, 0, 'h00, 'h00, 0), "ack", 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
